regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 117 +++++++++++
 tb/tb_regfile_sb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with an integrated write-pending
// scoreboard. NREAD asynchronous read ports, one writeback port and one
// issue port that marks a destination busy until its writeback arrives.
// Register 0 reads as zero and is never busy.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through
// forwarding on the read ports.
module regfile_sb #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NREAD      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREAD*ADDR_WIDTH-1:0]   ra,
    output logic [NREAD*WORD_WIDTH-1:0]   rd,
    output logic [NREAD-1:0]              rd_busy,
    input  logic                          iss_en,
    input  logic [ADDR_WIDTH-1:0]         iss_addr,
    output logic                          iss_waw,
    input  logic                          wb_en,
    input  logic [ADDR_WIDTH-1:0]         wb_addr,
    input  logic [WORD_WIDTH-1:0]         wb_data,
    input  logic                          flush,
    output logic [ADDR_WIDTH:0]           busy_cnt
);

    localparam int unsigned NREGS = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [WORD_WIDTH-1:0] regs_q [NREGS];
    logic [WORD_WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [CNT_W-1:0]      busy_cnt_q;
    logic [CNT_W-1:0]      busy_cnt_d;

    logic                  wb_hit;
    logic                  iss_hit;
    logic [ADDR_WIDTH-1:0] ra_port [NREAD];

    // Writes and issues to register 0 are ignored everywhere.
    assign wb_hit  = wb_en  && (wb_addr  != '0);
    assign iss_hit = iss_en && (iss_addr != '0);

    // Next-state: register write, busy update (flush > issue > writeback), popcount.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        busy_cnt_d = '0;
        if (wb_hit) begin
            regs_d[wb_addr] = wb_data;
        end
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_hit) begin
                busy_d[wb_addr] = 1'b0;
            end
            // Applied after the clear so a same-register issue wins.
            if (iss_hit) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Unpack the read address bus into one address per port.
    always_comb begin
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra_port[i] = ra[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Combinational read ports; address 0 reads zero and not busy.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            if (ra_port[i] != '0) begin
                rd[i*WORD_WIDTH +: WORD_WIDTH] = regs_q[ra_port[i]];
                rd_busy[i]                     = busy_q[ra_port[i]];
`ifdef REGFILE_BYPASS_EN
                // Forward the in-flight writeback; a same-cycle reissue keeps the stored busy bit.
                if (wb_hit && (ra_port[i] == wb_addr)) begin
                    rd[i*WORD_WIDTH +: WORD_WIDTH] = wb_data;
                    rd_busy[i] = (iss_hit && (iss_addr == wb_addr)) ? busy_q[ra_port[i]] : 1'b0;
                end
`endif
            end
        end
    end

    // Informational write-after-write flag for an issue to a busy register.
    assign iss_waw  = iss_hit && busy_q[iss_addr];
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default instance (2 ports, 32 regs) and
// a 4-port, 8-register instance. Stimulus pushes expected values into a
// queue; a monitor on the falling edge pops and compares.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_WAW  = 2;
    localparam int K_CNT  = 3;

    typedef struct {
        int          kind;
        int          inst;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    // Instance A: defaults.
    logic [9:0]  ra_a;
    logic [63:0] rd_a;
    logic [1:0]  rd_busy_a;
    logic        iss_en_a;
    logic [4:0]  iss_addr_a;
    logic        iss_waw_a;
    logic        wb_en_a;
    logic [4:0]  wb_addr_a;
    logic [31:0] wb_data_a;
    logic        flush_a;
    logic [5:0]  busy_cnt_a;

    // Instance B: NREAD=4, ADDR_WIDTH=3.
    logic [11:0]  ra_b;
    logic [127:0] rd_b;
    logic [3:0]   rd_busy_b;
    logic         iss_en_b;
    logic [2:0]   iss_addr_b;
    logic         iss_waw_b;
    logic         wb_en_b;
    logic [2:0]   wb_addr_b;
    logic [31:0]  wb_data_b;
    logic         flush_b;
    logic [3:0]   busy_cnt_b;

    exp_t sbq[$];
    exp_t e;
    logic [31:0] act;
    int n_cmp = 0;
    int n_err = 0;

    regfile_sb u_a (
        .clk(clk), .rst(rst), .ra(ra_a), .rd(rd_a), .rd_busy(rd_busy_a),
        .iss_en(iss_en_a), .iss_addr(iss_addr_a), .iss_waw(iss_waw_a),
        .wb_en(wb_en_a), .wb_addr(wb_addr_a), .wb_data(wb_data_a),
        .flush(flush_a), .busy_cnt(busy_cnt_a)
    );

    regfile_sb #(.WORD_WIDTH(32), .ADDR_WIDTH(3), .NREAD(4)) u_b (
        .clk(clk), .rst(rst), .ra(ra_b), .rd(rd_b), .rd_busy(rd_busy_b),
        .iss_en(iss_en_b), .iss_addr(iss_addr_b), .iss_waw(iss_waw_b),
        .wb_en(wb_en_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
        .flush(flush_b), .busy_cnt(busy_cnt_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int kind, input int inst, input int port);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_RD:   v = (inst == 0) ? rd_a[port*32 +: 32] : rd_b[port*32 +: 32];
            K_BUSY: v = (inst == 0) ? 32'(rd_busy_a[port]) : 32'(rd_busy_b[port]);
            K_WAW:  v = (inst == 0) ? 32'(iss_waw_a) : 32'(iss_waw_b);
            default: v = (inst == 0) ? 32'(busy_cnt_a) : 32'(busy_cnt_b);
        endcase
        return v;
    endfunction

    task automatic chk(input int kind, input int inst, input int port,
                       input logic [31:0] v, input string nm);
        exp_t x;
        x.kind = kind; x.inst = inst; x.port = port; x.val = v; x.name = nm;
        sbq.push_back(x);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step_a(input logic r, input logic ie, input logic [4:0] ia,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic fl, input logic [4:0] p0, input logic [4:0] p1);
        @(posedge clk);
        #1;
        rst = r; iss_en_a = ie; iss_addr_a = ia; wb_en_a = we; wb_addr_a = wa;
        wb_data_a = wd; flush_a = fl; ra_a = {p1, p0};
    endtask

    task automatic step_b(input logic ie, input logic [2:0] ia, input logic we,
                          input logic [2:0] wa, input logic [31:0] wd, input logic fl,
                          input logic [2:0] p0, input logic [2:0] p1,
                          input logic [2:0] p2, input logic [2:0] p3);
        @(posedge clk);
        #1;
        rst = 1'b0; iss_en_b = ie; iss_addr_b = ia; wb_en_b = we; wb_addr_b = wa;
        wb_data_b = wd; flush_b = fl; ra_b = {p3, p2, p1, p0};
    endtask

    // Monitor: all expectations queued during a cycle are checked mid-cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = actual(e.kind, e.inst, e.port);
            n_cmp++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        iss_en_a = 0; iss_addr_a = 0; wb_en_a = 0; wb_addr_a = 0; wb_data_a = 0; flush_a = 0; ra_a = 0;
        iss_en_b = 0; iss_addr_b = 0; wb_en_b = 0; wb_addr_b = 0; wb_data_b = 0; flush_b = 0; ra_b = 0;
        repeat (2) @(posedge clk);

        // Reset state
        step_a(0, 0, 0, 0, 0, 0, 0, 5, 0);
        chk(K_RD, 0, 0, 0, "reset_rd0"); chk(K_RD, 0, 1, 0, "reset_rd1");
        chk(K_BUSY, 0, 0, 0, "reset_busy0"); chk(K_BUSY, 0, 1, 0, "reset_busy1");
        chk(K_WAW, 0, 0, 0, "reset_waw"); chk(K_CNT, 0, 0, 0, "reset_cnt");
        chk(K_CNT, 1, 0, 0, "reset_cnt_b");
        // Write r5 then reset
        step_a(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0);
        chk(K_RD, 0, 0, BYP ? 32'hDEADBEEF : 32'h0, "wr5_same_cycle");
        step_a(1, 0, 0, 0, 0, 0, 0, 5, 0);
        chk(K_RD, 0, 0, 32'hDEADBEEF, "wr5_visible");
        step_a(0, 0, 0, 0, 0, 0, 0, 5, 5);
        chk(K_RD, 0, 0, 0, "rst_clears_r5_p0"); chk(K_RD, 0, 1, 0, "rst_clears_r5_p1");
        chk(K_CNT, 0, 0, 0, "rst_cnt");
        // Zero register
        step_a(0, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        chk(K_RD, 0, 0, 0, "r0_wr_same"); chk(K_BUSY, 0, 0, 0, "r0_busy_same");
        chk(K_WAW, 0, 0, 0, "r0_waw");
        step_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk(K_RD, 0, 0, 0, "r0_rd"); chk(K_BUSY, 0, 1, 0, "r0_busy");
        chk(K_CNT, 0, 0, 0, "r0_cnt");
        // Issue / writeback r3
        step_a(0, 1, 3, 0, 0, 0, 0, 3, 0);
        chk(K_WAW, 0, 0, 0, "iss3_waw"); chk(K_BUSY, 0, 0, 0, "iss3_busy_same");
        step_a(0, 0, 0, 1, 3, 32'h1234, 0, 3, 3);
        chk(K_BUSY, 0, 0, BYP ? 32'd0 : 32'd1, "wb3_busy0"); chk(K_BUSY, 0, 1, BYP ? 32'd0 : 32'd1, "wb3_busy1");
        chk(K_RD, 0, 0, BYP ? 32'h1234 : 32'h0, "wb3_rd0"); chk(K_CNT, 0, 0, 1, "wb3_cnt");
        step_a(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk(K_RD, 0, 0, 32'h1234, "r3_rd"); chk(K_BUSY, 0, 0, 0, "r3_busy"); chk(K_CNT, 0, 0, 0, "r3_cnt");
        // Simultaneous issue and writeback to r7
        step_a(0, 1, 7, 0, 0, 0, 0, 7, 0);
        chk(K_WAW, 0, 0, 0, "iss7_waw");
        step_a(0, 1, 7, 1, 7, 32'hA5A50007, 0, 7, 0);
        chk(K_WAW, 0, 0, 1, "iswb7_waw"); chk(K_BUSY, 0, 0, 1, "iswb7_busy");
        chk(K_RD, 0, 0, BYP ? 32'hA5A50007 : 32'h0, "iswb7_rd"); chk(K_CNT, 0, 0, 1, "iswb7_cnt");
        step_a(0, 1, 7, 0, 0, 0, 0, 7, 7);
        chk(K_WAW, 0, 0, 1, "reiss7_waw"); chk(K_RD, 0, 1, 32'hA5A50007, "r7_newdata");
        chk(K_BUSY, 0, 1, 1, "r7_still_busy"); chk(K_CNT, 0, 0, 1, "r7_cnt");
        step_a(0, 0, 0, 1, 7, 32'h77, 0, 7, 0);
        chk(K_RD, 0, 0, BYP ? 32'h77 : 32'hA5A50007, "wb7_rd"); chk(K_BUSY, 0, 0, BYP ? 32'd0 : 32'd1, "wb7_busy");
        step_a(0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk(K_RD, 0, 0, 32'h77, "r7_final"); chk(K_BUSY, 0, 0, 0, "r7_free"); chk(K_CNT, 0, 0, 0, "r7_cnt0");
        // Flush
        step_a(0, 1, 1, 0, 0, 0, 0, 1, 2);
        chk(K_CNT, 0, 0, 0, "fl_cnt0");
        step_a(0, 1, 2, 0, 0, 0, 0, 1, 2);
        chk(K_BUSY, 0, 0, 1, "fl_r1_busy"); chk(K_BUSY, 0, 1, 0, "fl_r2_not_yet"); chk(K_CNT, 0, 0, 1, "fl_cnt1");
        step_a(0, 1, 4, 0, 0, 0, 0, 2, 4);
        chk(K_BUSY, 0, 0, 1, "fl_r2_busy"); chk(K_BUSY, 0, 1, 0, "fl_r4_not_yet"); chk(K_CNT, 0, 0, 2, "fl_cnt2");
        step_a(0, 1, 9, 1, 4, 32'h44, 1, 4, 9);
        chk(K_CNT, 0, 0, 3, "fl_cnt3"); chk(K_BUSY, 0, 0, BYP ? 32'd0 : 32'd1, "fl_r4_busy");
        chk(K_RD, 0, 0, BYP ? 32'h44 : 32'h0, "fl_r4_rd"); chk(K_WAW, 0, 0, 0, "fl_waw9");
        step_a(0, 0, 0, 0, 0, 0, 0, 9, 4);
        chk(K_CNT, 0, 0, 0, "flush_cnt"); chk(K_BUSY, 0, 0, 0, "flush_r9_free");
        chk(K_RD, 0, 1, 32'h44, "flush_keeps_wb");
        // Reset mid-operation with a pending write
        step_a(0, 1, 9, 0, 0, 0, 0, 9, 0);
        step_a(1, 0, 0, 0, 0, 0, 0, 9, 0);
        chk(K_BUSY, 0, 0, 1, "pre_rst_r9_busy"); chk(K_CNT, 0, 0, 1, "pre_rst_cnt");
        step_a(0, 0, 0, 0, 0, 0, 0, 9, 3);
        chk(K_BUSY, 0, 0, 0, "mid_rst_busy"); chk(K_CNT, 0, 0, 0, "mid_rst_cnt");
        chk(K_RD, 0, 1, 0, "mid_rst_r3");

        // Instance B: 4 ports reading shared and distinct addresses
        step_b(0, 0, 1, 3, 32'h33, 0, 3, 3, 3, 5);
        for (int p = 0; p < 3; p++) chk(K_RD, 1, p, BYP ? 32'h33 : 32'h0, "b_wb3_same");
        chk(K_RD, 1, 3, 0, "b_r5_empty");
        step_b(0, 0, 1, 5, 32'h55, 0, 3, 5, 5, 3);
        chk(K_RD, 1, 0, 32'h33, "b_p0_r3"); chk(K_RD, 1, 3, 32'h33, "b_p3_r3");
        chk(K_RD, 1, 1, BYP ? 32'h55 : 32'h0, "b_p1_r5"); chk(K_RD, 1, 2, BYP ? 32'h55 : 32'h0, "b_p2_r5");
        step_b(0, 0, 0, 0, 0, 0, 1, 3, 5, 0);
        chk(K_RD, 1, 0, 0, "b_p0_r1"); chk(K_RD, 1, 1, 32'h33, "b_p1_r3");
        chk(K_RD, 1, 2, 32'h55, "b_p2_r5"); chk(K_RD, 1, 3, 0, "b_p3_r0");
        // Issue r1..r7; count lags by one cycle
        for (int k = 1; k <= 7; k++) begin
            step_b(1, 3'(k), 0, 0, 0, 0, 0, 0, 0, 0);
            chk(K_CNT, 1, 0, 32'(k - 1), "b_cnt_ramp");
            chk(K_WAW, 1, 0, 0, "b_ramp_waw");
        end
        step_b(1, 3, 0, 0, 0, 0, 1, 2, 6, 7);
        chk(K_CNT, 1, 0, 7, "b_cnt_full"); chk(K_WAW, 1, 0, 1, "b_waw3");
        for (int p = 0; p < 4; p++) chk(K_BUSY, 1, p, 1, "b_all_busy");
        step_b(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk(K_CNT, 1, 0, 7, "b_cnt_sat");
        step_b(0, 0, 0, 0, 0, 0, 7, 7, 7, 7);
        chk(K_CNT, 1, 0, 0, "b_cnt_flushed");
        for (int p = 0; p < 4; p++) chk(K_BUSY, 1, p, 0, "b_r7_free");

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
